// File: rtl/count_ctrl.sv
// count_ctrl: round controller for the countdown game. Sequences the
// countdown counter through idle, armed, locked, timeout (and foul) phases.
//
// Optional feature: define COUNT_CTRL_FOUL_EN to penalise button presses
// made in IDLE (FOUL state, foul/foul_id flags, score decrement).
//
// Ports:
//   clk        in  1   system clock, shared with the counter
//   rst        in  1   asynchronous, active-high reset
//   start      in  1   host start, rising edge begins a round
//   clr        in  1   host clear, level, leaves terminal states
//   btn        in  4   player buttons, active-high
//   time_sel   in  3   countdown seconds, sampled on the start edge
//   over       in  1   counter expiry flag
//   cst        out 1   counter run enable (low = clear/load)
//   num        out 3   counter load value
//   dzst       out 1   display enable
//   winner     out 2   index of winning player
//   winner_vld out 1   a player won the round
//   timeout    out 1   round expired with no press
//   foul       out 1   early press detected
//   foul_id    out 2   index of fouling player
//   score      out 16  four 4-bit scores, player i at [4i+3:4i]
module count_ctrl #(
    parameter logic [2:0] DEFAULT_TIME = 3'd7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        clr,
    input  logic [3:0]  btn,
    input  logic [2:0]  time_sel,
    input  logic        over,
    output logic        cst,
    output logic [2:0]  num,
    output logic        dzst,
    output logic [1:0]  winner,
    output logic        winner_vld,
    output logic        timeout,
    output logic        foul,
    output logic [1:0]  foul_id,
    output logic [15:0] score
);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        LOCKED,
        TIMEOUT,
        FOUL
    } state_t;

    state_t state;

    // Two-stage input pipeline: _r is the current sample, _p the previous
    // one, so an event is visible one edge after the raw input changes.
    logic       start_r;
    logic       start_p;
    logic [3:0] btn_r;
    logic [3:0] btn_p;
    logic       clr_r;

    logic       start_ev;
    logic [3:0] btn_ev;
    logic [1:0] pick;

    logic [3:0][3:0] sc;

    assign start_ev = start_r & ~start_p;
    assign btn_ev   = btn_r & ~btn_p;
    assign score    = sc;

    // Lowest-index button edge wins.
    always_comb begin
        pick = 2'd0;
        priority case (1'b1)
            btn_ev[0]: pick = 2'd0;
            btn_ev[1]: pick = 2'd1;
            btn_ev[2]: pick = 2'd2;
            btn_ev[3]: pick = 2'd3;
            default:   pick = 2'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            start_r    <= 1'b0;
            start_p    <= 1'b0;
            btn_r      <= 4'd0;
            btn_p      <= 4'd0;
            clr_r      <= 1'b0;
            cst        <= 1'b0;
            num        <= 3'd7;
            dzst       <= 1'b0;
            winner     <= 2'd0;
            winner_vld <= 1'b0;
            timeout    <= 1'b0;
            foul       <= 1'b0;
            foul_id    <= 2'd0;
            sc         <= '0;
        end else begin
            start_r <= start;
            start_p <= start_r;
            btn_r   <= btn;
            btn_p   <= btn_r;
            clr_r   <= clr;

            case (state)
                IDLE: begin
                    if (start_ev) begin
                        state <= ARMED;
                        num   <= (time_sel == 3'd0) ? DEFAULT_TIME
                                                    : time_sel;
                        cst   <= 1'b1;
                        dzst  <= 1'b1;
                    end
`ifdef COUNT_CTRL_FOUL_EN
                    else if (|btn_ev) begin
                        state   <= FOUL;
                        foul    <= 1'b1;
                        foul_id <= pick;
                        if (sc[pick] != 4'd0)
                            sc[pick] <= sc[pick] - 4'd1;
                    end
`endif
                end
                ARMED: begin
                    // A press in the same cycle as expiry still wins.
                    if (|btn_ev) begin
                        state      <= LOCKED;
                        cst        <= 1'b0;
                        winner     <= pick;
                        winner_vld <= 1'b1;
                        if (sc[pick] != 4'd15)
                            sc[pick] <= sc[pick] + 4'd1;
                    end else if (over) begin
                        state   <= TIMEOUT;
                        cst     <= 1'b0;
                        timeout <= 1'b1;
                    end
                end
                LOCKED, TIMEOUT, FOUL: begin
                    // Start edges seen here are dropped, not replayed.
                    if (clr_r) begin
                        state      <= IDLE;
                        dzst       <= 1'b0;
                        winner_vld <= 1'b0;
                        timeout    <= 1'b0;
                        foul       <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cst   <= 1'b0;
                    dzst  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_ctrl.sv
// tb_count_ctrl: directed self-checking bench for count_ctrl.
// Linear sequence of rounds with hand-computed expectations.
module tb_count_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        clr;
    logic [3:0]  btn;
    logic [2:0]  time_sel;
    logic        over;
    logic        cst;
    logic [2:0]  num;
    logic        dzst;
    logic [1:0]  winner;
    logic        winner_vld;
    logic        timeout;
    logic        foul;
    logic [1:0]  foul_id;
    logic [15:0] score;

    int n_assert = 0;
    int n_fail   = 0;

    count_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .clr        (clr),
        .btn        (btn),
        .time_sel   (time_sel),
        .over       (over),
        .cst        (cst),
        .num        (num),
        .dzst       (dzst),
        .winner     (winner),
        .winner_vld (winner_vld),
        .timeout    (timeout),
        .foul       (foul),
        .foul_id    (foul_id),
        .score      (score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Leaves the DUT in ARMED (two edges after the raw start edge).
    task automatic start_round(input logic [2:0] ts);
        time_sel = ts;
        start    = 1'b1;
        step(1);
        start    = 1'b0;
        step(1);
    endtask

    task automatic press(input logic [3:0] b);
        btn = b;
        step(1);
        btn = 4'd0;
        step(1);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        step(1);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        clr      = 1'b0;
        btn      = 4'd0;
        time_sel = 3'd0;
        over     = 1'b0;
        step(3);

        chk("rst_cst", cst, 0);
        chk("rst_num", num, 7);
        chk("rst_dzst", dzst, 0);
        chk("rst_winner", winner, 0);
        chk("rst_vld", winner_vld, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_foul", foul, 0);
        chk("rst_foul_id", foul_id, 0);
        chk("rst_score", score, 0);
        rst = 1'b0;
        step(2);

        // Normal win, with exact start latency
        time_sel = 3'd3;
        start    = 1'b1;
        step(1);
        chk("start_lat1_cst", cst, 0);
        start = 1'b0;
        step(1);
        chk("start_lat2_cst", cst, 1);
        chk("win_num", num, 3);
        chk("win_dzst_armed", dzst, 1);
        step(500);
        btn = 4'b0100;
        step(1);
        chk("press_lat1_vld", winner_vld, 0);
        btn = 4'd0;
        step(1);
        chk("win_winner", winner, 2);
        chk("win_vld", winner_vld, 1);
        chk("win_cst", cst, 0);
        chk("win_dzst", dzst, 1);
        chk("win_score2", score[11:8], 1);

        // clr and start together: clr wins, start edge is not replayed
        clr   = 1'b1;
        start = 1'b1;
        step(2);
        clr = 1'b0;
        chk("clr_vld", winner_vld, 0);
        chk("clr_winner_kept", winner, 2);
        chk("clr_dzst", dzst, 0);
        step(5);
        chk("start_consumed_cst", cst, 0);
        start = 1'b0;
        step(2);

        // Simultaneous press: lower index wins
        start_round(3'd5);
        chk("sim_num", num, 5);
        press(4'b1010);
        chk("sim_winner", winner, 1);
        chk("sim_score1", score[7:4], 1);
        do_clr();
        for (int i = 0; i < 15; i++) begin
            start_round(3'd5);
            press(4'b0010);
            do_clr();
        end
        chk("sat_score1", score[7:4], 15);
        chk("sat_score2_kept", score[11:8], 1);

        // over outside ARMED is ignored
        over = 1'b1;
        step(2);
        over = 1'b0;
        chk("over_idle_timeout", timeout, 0);

        // Timeout with default time
        start_round(3'd0);
        chk("to_num_default", num, 7);
        step(6990);
        chk("to_cst_running", cst, 1);
        over = 1'b1;
        step(1);
        over = 1'b0;
        chk("to_timeout", timeout, 1);
        chk("to_cst", cst, 0);
        chk("to_vld", winner_vld, 0);
        chk("to_dzst", dzst, 1);

        // btn[0] pressed in TIMEOUT is ignored and then held into next round
        btn = 4'b0001;
        step(3);
        chk("to_btn_ignored_vld", winner_vld, 0);
        chk("to_btn_ignored_score", score[3:0], 0);
        do_clr();
        chk("to_clr_timeout", timeout, 0);
        start_round(3'd4);
        chk("held_num", num, 4);
        step(30);
        chk("held_no_win", winner_vld, 0);
        over = 1'b1;
        step(1);
        over = 1'b0;
        chk("held_timeout", timeout, 1);
        chk("held_score0", score[3:0], 0);
        btn = 4'd0;
        step(2);
        do_clr();

        // Race: btn[3] edge and over in the same cycle
        start_round(3'd2);
        btn = 4'b1000;
        step(1);
        btn  = 4'd0;
        over = 1'b1;
        step(1);
        over = 1'b0;
        chk("race_winner", winner, 3);
        chk("race_vld", winner_vld, 1);
        chk("race_timeout", timeout, 0);
        chk("race_score3", score[15:12], 1);
        do_clr();

        // Press in IDLE
        press(4'b0100);
`ifdef COUNT_CTRL_FOUL_EN
        chk("foul_flag", foul, 1);
        chk("foul_id", foul_id, 2);
        chk("foul_score2", score[11:8], 0);
        chk("foul_dzst", dzst, 0);
        do_clr();
        chk("foul_clr", foul, 0);
        press(4'b0100);
        chk("foul2_flag", foul, 1);
        chk("foul2_score2", score[11:8], 0);
        do_clr();
`else
        chk("nofoul_flag", foul, 0);
        chk("nofoul_id", foul_id, 0);
        chk("nofoul_score2", score[11:8], 1);
        chk("nofoul_cst", cst, 0);
        chk("nofoul_dzst", dzst, 0);
`endif

        // Asynchronous reset mid-ARMED
        start_round(3'd3);
        step(5);
        chk("pre_rst_cst", cst, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_cst", cst, 0);
        chk("arst_dzst", dzst, 0);
        chk("arst_num", num, 7);
        chk("arst_winner", winner, 0);
        chk("arst_score", score, 0);
        step(2);
        rst = 1'b0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
